// File: rtl/gps_bridge_pkg.sv
// Shared definitions for the GPS sample bridge: packer states, default sizes, width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gps_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_PPS = 2'd1,
    ST_CAPTURE  = 2'd2
  } packer_state_e;

  localparam int DEF_SAMPLE_W         = 2;
  localparam int DEF_SAMPLES_PER_WORD = 8;

  // Bits needed to index 'value' distinct slots (minimum 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/gps_word_out_stage.sv
// Output word register with valid/ready handshake and saturating drop counter.
// Latency: a loaded word is visible (valid) the cycle after the load request.
// Backpressure: a word offered while the register is full and not being accepted is dropped and counted.
module gps_word_out_stage #(
  parameter int WORD_W    = 16,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_req_i,
  input  logic [WORD_W-1:0]    load_word_i,
  input  logic                 load_first_i,
  input  logic                 ready_i,
  input  logic                 ovf_clr_i,
  output logic                 load_ack_o,
  output logic [WORD_W-1:0]    word_o,
  output logic                 first_o,
  output logic                 valid_o,
  output logic [OVF_CNT_W-1:0] ovf_cnt_o
);

  logic [WORD_W-1:0]    word_q;
  logic                 first_q;
  logic                 valid_q;
  logic [OVF_CNT_W-1:0] ovf_q;
  logic                 drop;

  // The register can take a new word when empty or when its current word leaves this cycle.
  assign load_ack_o = load_req_i & (~valid_q | ready_i);
  assign drop       = load_req_i & ~load_ack_o;

  // Output register, valid flag and saturating drop counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q  <= '0;
      first_q <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      if (load_ack_o) begin
        word_q  <= load_word_i;
        first_q <= load_first_i;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end

      // A clear that coincides with a drop still records that drop.
      if (ovf_clr_i) begin
        ovf_q <= drop ? OVF_CNT_W'(1) : '0;
      end else if (drop && (ovf_q != {OVF_CNT_W{1'b1}})) begin
        ovf_q <= ovf_q + OVF_CNT_W'(1);
      end
    end
  end

  assign word_o    = word_q;
  assign first_o   = first_q;
  assign valid_o   = valid_q;
  assign ovf_cnt_o = ovf_q;

endmodule

// File: rtl/gps_sample_packer.sv
// Packs sign/magnitude GPS samples into host words, aligned to PPS, with a valid/ready output.
// Latency: a word is valid one cycle after its completing sample strobe.
// Backpressure: completed words that cannot be loaded are dropped and counted (saturating).
module gps_sample_packer
  import gps_bridge_pkg::*;
#(
  parameter int SAMPLE_W         = DEF_SAMPLE_W,
  parameter int SAMPLES_PER_WORD = DEF_SAMPLES_PER_WORD,
  parameter int OVF_CNT_W        = 8
) (
  input  logic                                 SYNC_CLK_IN,
  input  logic                                 RESET_IN,
  input  logic                                 ENABLE_IN,
  input  logic                                 PPS_STROBE_IN,
  input  logic                                 SAMPLE_STROBE_IN,
  input  logic [SAMPLE_W-1:0]                  SAMPLE_DATA_IN,
  output logic [SAMPLE_W*SAMPLES_PER_WORD-1:0] WORD_OUT,
  output logic                                 WORD_FIRST_OUT,
  output logic                                 WORD_VALID_OUT,
  input  logic                                 WORD_READY_IN,
  input  logic                                 OVERFLOW_CLR_IN,
  output logic [OVF_CNT_W-1:0]                 OVERFLOW_CNT_OUT,
  output logic                                 BUSY_OUT
);

  localparam int WORD_W = SAMPLE_W * SAMPLES_PER_WORD;
  localparam int SLOT_W = clog2(SAMPLES_PER_WORD);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SAMPLES_PER_WORD - 1);

  packer_state_e       state_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [WORD_W-1:0]   shreg_q;
  logic                first_q;

  logic [WORD_W-1:0]   word_cmb;
  logic                load_req;
  logic                load_ack;

  // Current partial word with this cycle's sample dropped into its slot; also the completed word.
  always_comb begin
    word_cmb = shreg_q;
    word_cmb[slot_q*SAMPLE_W +: SAMPLE_W] = SAMPLE_DATA_IN;
  end

  // A word completes on a strobe at the last slot, unless PPS realigns in the same cycle.
  assign load_req = ENABLE_IN && (state_q == ST_CAPTURE) && !PPS_STROBE_IN &&
                    SAMPLE_STROBE_IN && (slot_q == LAST_SLOT);

  // Packer FSM: arming, PPS alignment, slot sequencing and first-word flag.
  always_ff @(posedge SYNC_CLK_IN) begin
    if (RESET_IN) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      shreg_q <= '0;
      first_q <= 1'b0;
    end else if (!ENABLE_IN) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      shreg_q <= '0;
      first_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_q <= ST_WAIT_PPS;
    end else if (PPS_STROBE_IN) begin
      // Align (or realign): drop any partial word, a coincident sample becomes slot 0.
      state_q <= ST_CAPTURE;
      first_q <= 1'b1;
      shreg_q <= '0;
      if (SAMPLE_STROBE_IN) begin
        shreg_q[SAMPLE_W-1:0] <= SAMPLE_DATA_IN;
        slot_q                <= SLOT_W'(1);
      end else begin
        slot_q <= '0;
      end
    end else if ((state_q == ST_CAPTURE) && SAMPLE_STROBE_IN) begin
      if (slot_q == LAST_SLOT) begin
        slot_q  <= '0;
        shreg_q <= '0;
        // The first flag survives a dropped word so the next delivered word carries it.
        if (load_ack) first_q <= 1'b0;
      end else begin
        shreg_q <= word_cmb;
        slot_q  <= slot_q + SLOT_W'(1);
      end
    end
  end

  gps_word_out_stage #(
    .WORD_W    (WORD_W),
    .OVF_CNT_W (OVF_CNT_W)
  ) u_out_stage (
    .clk_i        (SYNC_CLK_IN),
    .rst_i        (RESET_IN),
    .load_req_i   (load_req),
    .load_word_i  (word_cmb),
    .load_first_i (first_q),
    .ready_i      (WORD_READY_IN),
    .ovf_clr_i    (OVERFLOW_CLR_IN),
    .load_ack_o   (load_ack),
    .word_o       (WORD_OUT),
    .first_o      (WORD_FIRST_OUT),
    .valid_o      (WORD_VALID_OUT),
    .ovf_cnt_o    (OVERFLOW_CNT_OUT)
  );

  assign BUSY_OUT = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gps_sample_packer.sv
// Directed and randomized checks of gps_sample_packer against a sample-queue reference model.
module tb_gps_sample_packer;

  logic        SYNC_CLK_IN = 1'b0;
  logic        RESET_IN = 1'b1;
  logic        ENABLE_IN = 1'b0;
  logic        PPS_STROBE_IN = 1'b0;
  logic        SAMPLE_STROBE_IN = 1'b0;
  logic [1:0]  SAMPLE_DATA_IN = 2'd0;
  logic [15:0] WORD_OUT;
  logic        WORD_FIRST_OUT;
  logic        WORD_VALID_OUT;
  logic        WORD_READY_IN = 1'b0;
  logic        OVERFLOW_CLR_IN = 1'b0;
  logic [7:0]  OVERFLOW_CNT_OUT;
  logic        BUSY_OUT;

  int tests = 0;
  int fails = 0;

  gps_sample_packer #(
    .SAMPLE_W         (2),
    .SAMPLES_PER_WORD (8),
    .OVF_CNT_W        (8)
  ) dut (
    .SYNC_CLK_IN      (SYNC_CLK_IN),
    .RESET_IN         (RESET_IN),
    .ENABLE_IN        (ENABLE_IN),
    .PPS_STROBE_IN    (PPS_STROBE_IN),
    .SAMPLE_STROBE_IN (SAMPLE_STROBE_IN),
    .SAMPLE_DATA_IN   (SAMPLE_DATA_IN),
    .WORD_OUT         (WORD_OUT),
    .WORD_FIRST_OUT   (WORD_FIRST_OUT),
    .WORD_VALID_OUT   (WORD_VALID_OUT),
    .WORD_READY_IN    (WORD_READY_IN),
    .OVERFLOW_CLR_IN  (OVERFLOW_CLR_IN),
    .OVERFLOW_CNT_OUT (OVERFLOW_CNT_OUT),
    .BUSY_OUT         (BUSY_OUT)
  );

  always #5 SYNC_CLK_IN = ~SYNC_CLK_IN;

  // Advance one clock; outputs are observed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge SYNC_CLK_IN);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // n back-to-back strobes carrying the same sample value.
  task automatic strobes(input int n, input logic [1:0] d);
    for (int i = 0; i < n; i++) begin
      SAMPLE_STROBE_IN = 1'b1;
      SAMPLE_DATA_IN   = d;
      tick();
    end
    SAMPLE_STROBE_IN = 1'b0;
  endtask

  // Reference model state for the random phase.
  logic [1:0]  samp_q[$];
  logic [16:0] exp_q[$];
  bit          m_valid;
  bit          m_first;
  int          drops;
  int          w;

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_valid", WORD_VALID_OUT, 1'b0);
    chk("rst_word", WORD_OUT, 16'h0000);
    chk("rst_first", WORD_FIRST_OUT, 1'b0);
    chk("rst_ovf", OVERFLOW_CNT_OUT, 8'd0);
    chk("rst_busy", BUSY_OUT, 1'b0);
    RESET_IN = 1'b0;

    // ---------------- basic word 0xE4E4 ----------------
    ENABLE_IN = 1'b1;
    WORD_READY_IN = 1'b1;
    tick();
    chk("arm_busy", BUSY_OUT, 1'b1);
    PPS_STROBE_IN = 1'b1;
    tick();
    PPS_STROBE_IN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("basic_novalid", WORD_VALID_OUT, 1'b0);
      SAMPLE_STROBE_IN = 1'b1;
      SAMPLE_DATA_IN   = 2'(i % 4);
      tick();
    end
    SAMPLE_STROBE_IN = 1'b0;
    chk("basic_valid", WORD_VALID_OUT, 1'b1);
    chk("basic_word", WORD_OUT, 16'hE4E4);
    chk("basic_first", WORD_FIRST_OUT, 1'b1);
    tick();
    chk("basic_one_cycle", WORD_VALID_OUT, 1'b0);

    // ---------------- strobes before PPS ignored, PPS-coincident strobe is slot 0 ----------------
    ENABLE_IN = 1'b0;
    tick();
    ENABLE_IN = 1'b1;
    tick();
    strobes(3, 2'd2);
    PPS_STROBE_IN = 1'b1;
    SAMPLE_STROBE_IN = 1'b1;
    SAMPLE_DATA_IN = 2'd3;
    tick();
    PPS_STROBE_IN = 1'b0;
    strobes(7, 2'd0);
    chk("pps_coinc_valid", WORD_VALID_OUT, 1'b1);
    chk("pps_coinc_word", WORD_OUT, 16'h0003);
    chk("pps_coinc_first", WORD_FIRST_OUT, 1'b1);
    tick();

    // ---------------- back-pressure: hold first word, count drops ----------------
    WORD_READY_IN = 1'b0;
    PPS_STROBE_IN = 1'b1;
    tick();
    PPS_STROBE_IN = 1'b0;
    strobes(8, 2'd1);
    strobes(16, 2'd3);
    chk("bp_valid", WORD_VALID_OUT, 1'b1);
    chk("bp_word_stable", WORD_OUT, 16'h5555);
    chk("bp_first_stable", WORD_FIRST_OUT, 1'b1);
    chk("bp_ovf", OVERFLOW_CNT_OUT, 8'd2);
    WORD_READY_IN = 1'b1;
    tick();
    chk("bp_accept", WORD_VALID_OUT, 1'b0);
    strobes(8, 2'd3);
    chk("bp_next_word", WORD_OUT, 16'hFFFF);
    chk("bp_next_nofirst", WORD_FIRST_OUT, 1'b0);
    tick();
    OVERFLOW_CLR_IN = 1'b1;
    tick();
    OVERFLOW_CLR_IN = 1'b0;
    chk("clr_ovf", OVERFLOW_CNT_OUT, 8'd0);

    // ---------------- completion in the same cycle as accept ----------------
    WORD_READY_IN = 1'b0;
    strobes(8, 2'd1);
    strobes(7, 2'd2);
    chk("same_cyc_hold", WORD_OUT, 16'h5555);
    WORD_READY_IN = 1'b1;
    strobes(1, 2'd2);
    chk("same_cyc_valid", WORD_VALID_OUT, 1'b1);
    chk("same_cyc_word", WORD_OUT, 16'hAAAA);
    chk("same_cyc_ovf", OVERFLOW_CNT_OUT, 8'd0);
    tick();
    chk("same_cyc_drain", WORD_VALID_OUT, 1'b0);

    // ---------------- PPS realign mid-word ----------------
    strobes(5, 2'd3);
    PPS_STROBE_IN = 1'b1;
    tick();
    PPS_STROBE_IN = 1'b0;
    for (int i = 0; i < 7; i++) begin
      SAMPLE_STROBE_IN = 1'b1;
      SAMPLE_DATA_IN   = (i == 0) ? 2'd1 : 2'd0;
      tick();
      chk("realign_no_early", WORD_VALID_OUT, 1'b0);
    end
    strobes(1, 2'd0);
    chk("realign_word", WORD_OUT, 16'h0001);
    chk("realign_first", WORD_FIRST_OUT, 1'b1);
    tick();

    // ---------------- disable mid-word ----------------
    strobes(3, 2'd2);
    ENABLE_IN = 1'b0;
    tick();
    chk("dis_busy", BUSY_OUT, 1'b0);
    strobes(8, 2'd2);
    chk("dis_noword", WORD_VALID_OUT, 1'b0);
    ENABLE_IN = 1'b1;
    tick();

    // ---------------- overflow saturation and clear-with-drop ----------------
    PPS_STROBE_IN = 1'b1;
    tick();
    PPS_STROBE_IN = 1'b0;
    WORD_READY_IN = 1'b0;
    for (int k = 0; k < 257; k++) strobes(8, 2'd2);
    chk("sat_ovf", OVERFLOW_CNT_OUT, 8'd255);
    chk("sat_valid", WORD_VALID_OUT, 1'b1);
    strobes(7, 2'd1);
    OVERFLOW_CLR_IN = 1'b1;
    strobes(1, 2'd1);
    OVERFLOW_CLR_IN = 1'b0;
    chk("clr_with_drop", OVERFLOW_CNT_OUT, 8'd1);

    // ---------------- reset mid-handshake ----------------
    RESET_IN = 1'b1;
    tick();
    chk("rst_mid_valid", WORD_VALID_OUT, 1'b0);
    chk("rst_mid_ovf", OVERFLOW_CNT_OUT, 8'd0);
    chk("rst_mid_busy", BUSY_OUT, 1'b0);
    RESET_IN = 1'b0;

    // ---------------- randomized run against the sample-queue model ----------------
    ENABLE_IN = 1'b1;
    tick();
    PPS_STROBE_IN = 1'b1;
    tick();
    samp_q.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_first = 1'b1;
    drops   = 0;
    for (int c = 0; c < 3000; c++) begin
      PPS_STROBE_IN    = ($urandom_range(0, 39) == 0);
      SAMPLE_STROBE_IN = $urandom_range(0, 1) != 0;
      SAMPLE_DATA_IN   = 2'($urandom_range(0, 3));
      WORD_READY_IN    = (c < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);

      chk("rnd_valid", WORD_VALID_OUT, m_valid);
      if (m_valid && WORD_READY_IN) begin
        chk("rnd_word", WORD_OUT, exp_q[0][15:0]);
        chk("rnd_first", WORD_FIRST_OUT, exp_q[0][16]);
        void'(exp_q.pop_front());
        m_valid = 1'b0;
      end

      if (PPS_STROBE_IN) begin
        samp_q.delete();
        m_first = 1'b1;
        if (SAMPLE_STROBE_IN) samp_q.push_back(SAMPLE_DATA_IN);
      end else if (SAMPLE_STROBE_IN) begin
        samp_q.push_back(SAMPLE_DATA_IN);
        if (samp_q.size() == 8) begin
          w = 0;
          for (int i = 0; i < 8; i++) w = w + int'(samp_q[i]) * (4 ** i);
          if (!m_valid) begin
            exp_q.push_back({m_first, 16'(w)});
            m_first = 1'b0;
            m_valid = 1'b1;
          end else begin
            drops++;
          end
          samp_q.delete();
        end
      end
      tick();
    end
    PPS_STROBE_IN    = 1'b0;
    SAMPLE_STROBE_IN = 1'b0;
    chk("rnd_ovf", OVERFLOW_CNT_OUT, (drops > 255) ? 255 : drops);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gps_sample_packer.md
Name: gps_sample_packer

Overview:
Control block behind the front-end sample-clock edge detector in the CPLD bridge. It sequences capture of sign/magnitude GPS samples on each synchronized sample strobe and aligns word boundaries to the synchronized PPS strobe. It packs samples into host-width words and hands them to the host side over a valid/ready handshake, counting words lost to back-pressure.

Parameters:
SAMPLE_W, 2, bits per front-end sample (sign, magnitude)
SAMPLES_PER_WORD, 8, samples packed per output word (power of two, >=2)
OVF_CNT_W, 8, width of saturating overflow counter
WORD_W (localparam), SAMPLE_W*SAMPLES_PER_WORD, output word width

Ports:
SYNC_CLK_IN  in  1  single system clock; all logic on rising edge
RESET_IN  in  1  synchronous, active-high reset
ENABLE_IN  in  1  level; 1 = arm and capture, 0 = return to idle
PPS_STROBE_IN  in  1  one-cycle pulse, synchronized PPS rising edge
SAMPLE_STROBE_IN  in  1  one-cycle pulse, synchronized sample-clock rising edge
SAMPLE_DATA_IN  in  SAMPLE_W  sample value, valid when SAMPLE_STROBE_IN=1
WORD_OUT  out  WORD_W  packed word
WORD_FIRST_OUT  out  1  word is first after a PPS alignment
WORD_VALID_OUT  out  1  WORD_OUT holds an unaccepted word
WORD_READY_IN  in  1  host accepts word when VALID&READY
OVERFLOW_CLR_IN  in  1  one-cycle clear of overflow counter
OVERFLOW_CNT_OUT  out  OVF_CNT_W  words dropped, saturating
BUSY_OUT  out  1  state != IDLE

Behaviour:
- Reset (RESET_IN=1 at a clock edge): state IDLE, slot counter 0, shift register 0, all outputs 0. This includes dropping any pending word. Reset mid-capture or mid-handshake gives the same result.
- States:
  - IDLE: ENABLE_IN=1 -> WAIT_PPS.
  - WAIT_PPS: PPS_STROBE_IN=1 -> CAPTURE, slot counter 0, first-flag set.
  - CAPTURE: stays in CAPTURE while ENABLE_IN=1.
- ENABLE_IN=0 in any state -> IDLE next cycle. The partial word is discarded. A word already in the output register stays valid until accepted.
- Capture: in CAPTURE, each SAMPLE_STROBE_IN writes SAMPLE_DATA_IN into bits [slot*SAMPLE_W +: SAMPLE_W], and the slot counter increments. Slot 0 is the LSBs.
- A strobe in the same cycle as the PPS that enters CAPTURE is taken as slot 0.
- Strobes are ignored in IDLE and in WAIT_PPS (except the PPS cycle above).
- Word completion: a strobe at slot SAMPLES_PER_WORD-1 completes the word and the slot counter wraps to 0.
  - Load case: if the output register is empty, or is being accepted this same cycle, the completed word loads. WORD_VALID_OUT=1 on the next cycle, giving 1-cycle latency from the completing strobe.
  - WORD_FIRST_OUT takes the first-flag, and the first-flag then clears.
  - Drop case: otherwise the completed word is dropped and OVERFLOW_CNT_OUT increments, saturating at all-ones. The first-flag is not consumed, so the next delivered word carries it.
- Handshake: WORD_OUT and WORD_FIRST_OUT are stable while VALID=1 and READY=0. VALID clears the cycle after acceptance unless a new word loads in the same cycle, in which case VALID stays 1 with the new data.
- READY while VALID=0 has no effect.
- PPS during CAPTURE: realigns. The partial word is discarded, slot counter goes to 0, and the first-flag is set. A coincident strobe becomes slot 0 of the new word.
- PPS coinciding with a completing strobe: PPS wins. The sample goes to slot 0 of the new word, the old partial word is discarded, and no overflow is counted.
- OVERFLOW_CLR_IN coinciding with an overflow event: counter = 1.
- Back-to-back strobes on consecutive cycles are handled with no loss.

Decomposition:
- Shared package gps_bridge_pkg:
  - packer state encoding (IDLE, WAIT_PPS, CAPTURE)
  - default SAMPLE_W and SAMPLES_PER_WORD constants
  - the slot-counter width function clog2
- One sub-module, gps_word_out_stage: output register plus valid/ready/load logic. It reports an accept/overflow decision back to the packer FSM.

Test Plan:
- Reset, ENABLE=1, PPS pulse, then 8 strobes with data 0,1,2,3,0,1,2,3, READY=1 -> one word 0xE4E4, FIRST=1, VALID for exactly 1 cycle, 1 cycle after the 8th strobe.
- Strobes before PPS, then PPS coincident with a strobe carrying data 3, then 7 strobes of 0 -> word 0x0003, FIRST=1. Earlier strobes are ignored.
- READY=0, capture 3 full words of 0xFFFF pattern (sample 3) -> first word held stable, OVERFLOW_CNT_OUT=2. READY=1 then gives one accept with no FIRST on later words.
- Completing strobe in the same cycle as the accept of the previous word -> VALID stays 1, new word visible next cycle, overflow count stays 0.
- PPS after 5 strobes in CAPTURE -> partial word discarded, next 8 strobes give a word with FIRST=1. ENABLE=0 mid-word -> BUSY_OUT=0 next cycle and no word emitted.
- Overflow counter driven to 255 with one further drop -> stays 255. Assert OVERFLOW_CLR_IN together with a drop -> 1. RESET_IN mid-handshake -> VALID=0 and count=0 next cycle.
